multicycle_control_fsm: RTL and testbench

// Multicycle MIPS control FSM. Sequences the shared datapath (one memory, one ALU, PC, IR, register file), one instruction at a time.

---
 rtl/multicycle_control_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM: sequences the shared datapath one instruction at a time.
// Optional MC_MEM_WAIT_EN adds mem_ready and stalls FETCH/MEMRD/MEMWR until it is high.
module multicycle_control_fsm #(
   parameter int ST_W    = 4,
   parameter int ALUOP_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         func,
`ifdef MC_MEM_WAIT_EN
   input  logic               mem_ready,
`endif
   output logic               PCWrite,
   output logic               Branch,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSrc,
   output logic [ALUOP_W-1:0] ALUOP,
   output logic               illegal_op,
   output logic               instr_done,
   output logic [ST_W-1:0]    state
);

   typedef enum logic [ST_W-1:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      RTEXE  = 4'd6,
      RTWB   = 4'd7,
      BRANCH = 4'd8,
      IMMEXE = 4'd9,
      IMMWB  = 4'd10,
      JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'd0;
   localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'd1;
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = 4'd2;
   localparam logic [ALUOP_W-1:0] ALU_AND   = 4'd3;
   localparam logic [ALUOP_W-1:0] ALU_OR    = 4'd4;
   localparam logic [ALUOP_W-1:0] ALU_LUI   = 4'd5;

   state_t state_q, state_d;
   logic   mem_rdy;

`ifdef MC_MEM_WAIT_EN
   assign mem_rdy = mem_ready;
`else
   assign mem_rdy = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = FETCH;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      MemtoReg   = 1'b0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'd0;
      PCSrc      = 2'd0;
      ALUOP      = ALU_ADD;
      illegal_op = 1'b0;
      instr_done = 1'b0;
      state      = state_q;

      case (state_q)
         DECODE: begin
            ALUSrcB = 2'd3;
            unique case (opcode)
               OP_LW, OP_SW:                    state_d = MEMADR;
               OP_BEQ:                          state_d = BRANCH;
               OP_J:                            state_d = JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = IMMEXE;
               OP_RTYPE: begin
                  if (func == 6'd0) instr_done = 1'b1;
                  else              state_d    = RTEXE;
               end
               default: begin
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            state_d = mem_rdy ? MEMWB : MEMRD;
         end
         MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         MEMWR: begin
            IorD       = 1'b1;
            MemWrite   = 1'b1;
            instr_done = mem_rdy;
            state_d    = mem_rdy ? FETCH : MEMWR;
         end
         RTEXE: begin
            ALUSrcA = 1'b1;
            ALUOP   = ALU_FUNCT;
            state_d = RTWB;
         end
         RTWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUOP      = ALU_SUB;
            Branch     = 1'b1;
            PCSrc      = 2'd1;
            instr_done = 1'b1;
         end
         IMMEXE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            case (opcode)
               OP_ANDI: ALUOP = ALU_AND;
               OP_ORI:  ALUOP = ALU_OR;
               OP_LUI:  ALUOP = ALU_LUI;
               default: ALUOP = ALU_ADD;
            endcase
            state_d = IMMWB;
         end
         IMMWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         JUMP: begin
            PCWrite    = 1'b1;
            PCSrc      = 2'd2;
            instr_done = 1'b1;
         end
         // FETCH and the unused codes 12-15 share the fetch behaviour.
         default: begin
            MemRead = 1'b1;
            IRWrite = mem_rdy;
            PCWrite = mem_rdy;
            ALUSrcB = 2'd1;
            state_d = mem_rdy ? DECODE : FETCH;
         end
      endcase

      if (rst) begin
         PCWrite    = 1'b0;
         Branch     = 1'b0;
         IorD       = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         MemtoReg   = 1'b0;
         RegDst     = 1'b0;
         RegWrite   = 1'b0;
         ALUSrcA    = 1'b0;
         ALUSrcB    = 2'd0;
         PCSrc      = 2'd0;
         ALUOP      = '0;
         illegal_op = 1'b0;
         instr_done = 1'b0;
         state      = '0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; expected values hand-derived per instruction.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, func;
`ifdef MC_MEM_WAIT_EN
   logic       mem_ready;
`endif
   logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic [3:0] ALUOP, state;
   logic       illegal_op, instr_done;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.ST_W(4), .ALUOP_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .func       (func),
`ifdef MC_MEM_WAIT_EN
      .mem_ready  (mem_ready),
`endif
      .PCWrite    (PCWrite),
      .Branch     (Branch),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .MemtoReg   (MemtoReg),
      .RegDst     (RegDst),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .PCSrc      (PCSrc),
      .ALUOP      (ALUOP),
      .illegal_op (illegal_op),
      .instr_done (instr_done),
      .state      (state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic [3:0] exp_state);
      @(posedge clk);
      #1;
      chk("state", {28'd0, state}, {28'd0, exp_state});
   endtask

   initial begin
      rst    = 1'b1;
      opcode = 6'h23;
      func   = 6'h00;
`ifdef MC_MEM_WAIT_EN
      mem_ready = 1'b1;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state",   {28'd0, state}, 32'd0);
      chk("rst_memread", {31'd0, MemRead}, 32'd0);
      chk("rst_pcwrite", {31'd0, PCWrite}, 32'd0);

      // lw: 0,1,2,3,4
      rst = 1'b0;
      #1;
      chk("fetch_state",   {28'd0, state}, 32'd0);
      chk("fetch_memread", {31'd0, MemRead}, 32'd1);
      chk("fetch_irwrite", {31'd0, IRWrite}, 32'd1);
      chk("fetch_pcwrite", {31'd0, PCWrite}, 32'd1);
      chk("fetch_srcb",    {30'd0, ALUSrcB}, 32'd1);
      step(4'd1);
      chk("dec_srcb", {30'd0, ALUSrcB}, 32'd3);
      chk("dec_ill",  {31'd0, illegal_op}, 32'd0);
      step(4'd2);
      chk("madr_srca", {31'd0, ALUSrcA}, 32'd1);
      chk("madr_srcb", {30'd0, ALUSrcB}, 32'd2);
      step(4'd3);
      chk("mrd_iord",  {31'd0, IorD}, 32'd1);
      chk("mrd_regwr", {31'd0, RegWrite}, 32'd0);
      chk("mrd_m2r",   {31'd0, MemtoReg}, 32'd0);
      step(4'd4);
      chk("mwb_regwr", {31'd0, RegWrite}, 32'd1);
      chk("mwb_m2r",   {31'd0, MemtoReg}, 32'd1);
      chk("mwb_dst",   {31'd0, RegDst}, 32'd0);
      chk("mwb_done",  {31'd0, instr_done}, 32'd1);

      // beq: 0,1,8
      step(4'd0);
      opcode = 6'h04;
      chk("f_m2r", {31'd0, MemtoReg}, 32'd0);
      step(4'd1);
      chk("beq_dec_done", {31'd0, instr_done}, 32'd0);
      step(4'd8);
      chk("beq_branch", {31'd0, Branch}, 32'd1);
      chk("beq_aluop",  {28'd0, ALUOP}, 32'd1);
      chk("beq_pcsrc",  {30'd0, PCSrc}, 32'd1);
      chk("beq_done",   {31'd0, instr_done}, 32'd1);

      // nop: 0,1,0
      step(4'd0);
      opcode = 6'h00;
      func   = 6'h00;
      step(4'd1);
      chk("nop_done",  {31'd0, instr_done}, 32'd1);
      chk("nop_regwr", {31'd0, RegWrite}, 32'd0);
      chk("nop_ill",   {31'd0, illegal_op}, 32'd0);

      // illegal opcode 0x3F
      step(4'd0);
      opcode = 6'h3F;
      step(4'd1);
      chk("ill_flag", {31'd0, illegal_op}, 32'd1);
      chk("ill_done", {31'd0, instr_done}, 32'd1);

      // ori: 0,1,9,10
      step(4'd0);
      opcode = 6'h0D;
      chk("ill_clr", {31'd0, illegal_op}, 32'd0);
      step(4'd1);
      step(4'd9);
      chk("ori_aluop", {28'd0, ALUOP}, 32'd4);
      chk("ori_srcb",  {30'd0, ALUSrcB}, 32'd2);
      chk("ori_srca",  {31'd0, ALUSrcA}, 32'd1);
      step(4'd10);
      chk("ori_regwr", {31'd0, RegWrite}, 32'd1);
      chk("ori_dst",   {31'd0, RegDst}, 32'd0);
      chk("ori_done",  {31'd0, instr_done}, 32'd1);

      // lui: ALUOP 5
      step(4'd0);
      opcode = 6'h0F;
      step(4'd1);
      step(4'd9);
      chk("lui_aluop", {28'd0, ALUOP}, 32'd5);

      // R-type add: 0,1,6,7
      step(4'd10);
      step(4'd0);
      opcode = 6'h00;
      func   = 6'h20;
      step(4'd1);
      step(4'd6);
      chk("rt_aluop", {28'd0, ALUOP}, 32'd2);
      chk("rt_srcb",  {30'd0, ALUSrcB}, 32'd0);
      step(4'd7);
      chk("rt_dst",   {31'd0, RegDst}, 32'd1);
      chk("rt_regwr", {31'd0, RegWrite}, 32'd1);

      // j: 0,1,11
      step(4'd0);
      opcode = 6'h02;
      step(4'd1);
      step(4'd11);
      chk("j_pcwrite", {31'd0, PCWrite}, 32'd1);
      chk("j_pcsrc",   {30'd0, PCSrc}, 32'd2);
      chk("j_done",    {31'd0, instr_done}, 32'd1);

      // sw with reset asserted in MEMWR
      step(4'd0);
      opcode = 6'h2B;
      step(4'd1);
      step(4'd2);
      step(4'd5);
      chk("sw_memwr", {31'd0, MemWrite}, 32'd1);
      chk("sw_iord",  {31'd0, IorD}, 32'd1);
      chk("sw_done",  {31'd0, instr_done}, 32'd1);
      rst = 1'b1;
      #1;
      chk("swrst_memwr", {31'd0, MemWrite}, 32'd0);
      chk("swrst_done",  {31'd0, instr_done}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("post_rst_state", {28'd0, state}, 32'd0);
      chk("post_rst_mrd",   {31'd0, MemRead}, 32'd1);

`ifdef MC_MEM_WAIT_EN
      mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("wait_irwrite", {31'd0, IRWrite}, 32'd0);
         chk("wait_memread", {31'd0, MemRead}, 32'd1);
         step(4'd0);
      end
      mem_ready = 1'b1;
      #1;
      chk("ready_irwrite", {31'd0, IRWrite}, 32'd1);
      chk("ready_pcwrite", {31'd0, PCWrite}, 32'd1);
      step(4'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
